blink_stream_ctrl: RTL and testbench

Streaming front-end controller for the registered 64-bit Blink cipher core (`Blink_clk`). It loads the 448-bit round-key vector as seven 64-bit words over a valid/ready port and accepts tweak/data blocks over a second valid/ready port. It tracks blocks in flight through the core's fixed 2-cycle latency and returns results in order through a credit-protected output FIFO with valid/ready backpressure. It sits directly upstream of `Blink_clk` and drives its `enc`/`K0`/`P`/`T` inputs; its `C` output comes back through this block.

---
 rtl/blink_pkg.sv | 30 +++
 rtl/blink_result_fifo.sv | 61 ++++++
 rtl/blink_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_blink_stream_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants, FSM encoding and result-entry layout for the Blink
// streaming front-end.
package blink_pkg;

  localparam int N      = 64;
  localparam int TWEAK  = 64;
  localparam int KWORDS = 7;
  localparam int LAT    = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic         enc;
    logic [N-1:0] data;
  } result_t;

  function automatic int unsigned popcount(input logic [LAT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < LAT; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/blink_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible while the
// FIFO is non-empty and reads as zero when empty.
module blink_result_fifo
  import blink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  result_t                    i_data,
  input  logic                       i_pop,
  output result_t                    o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  result_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = i_pop && (r_count != '0);

  // NOTE: the storage array carries no reset; occupancy is tracked by the
  // reset counters, and the empty-gated read path hides stale contents.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/blink_stream_ctrl.sv
// Streaming front-end for the registered Blink core: key loading, credit-
// checked block issue, in-flight tracking and in-order result buffering.
module blink_stream_ctrl
  import blink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [N-1:0]          key_word,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic                  blk_enc,
  input  logic [TWEAK-1:0]      blk_tweak,
  input  logic [N-1:0]          blk_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_data,
  output logic                  out_enc,
  output logic                  cip_enc,
  output logic [N-1:0]          cip_P,
  output logic [TWEAK-1:0]      cip_T,
  output logic [N*KWORDS-1:0]   cip_K0,
  input  logic [N-1:0]          cip_C
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e              r_state;
  logic [2:0]          r_wcnt;
  logic [N*KWORDS-1:0] r_k0;
  logic [LAT-1:0]      r_vld;
  logic [LAT-1:0]      r_enc;

  logic [CW-1:0]       w_fifo_count;
  logic                w_fifo_empty;
  logic [31:0]         w_inflight;
  logic [31:0]         w_occupancy;
  logic                w_key_fire;
  logic                w_blk_fire;
  logic                w_pop;
  result_t             w_push_data;
  result_t             w_head;

  // NOTE: every combinational output gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_inflight  = popcount(r_vld);
    w_occupancy = 32'(w_fifo_count) + w_inflight;
  end

  // Readiness is a function of registered state only; reset forces it low.
  assign key_ready  = rst && (r_state == ST_LOAD);
  assign blk_ready  = rst && (r_state == ST_RUN) && (w_occupancy < 32'(DEPTH));
  assign w_key_fire = key_valid && key_ready;
  assign w_blk_fire = blk_valid && blk_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_wcnt  <= '0;
      r_k0    <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_key_fire) begin
            r_k0[32'(r_wcnt)*N +: N] <= key_word;
            if (r_wcnt == 3'(KWORDS - 1)) begin
              r_wcnt  <= '0;
              r_state <= ST_RUN;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (key_valid) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // K0 only changes once no accepted block can still sample it.
          if (w_inflight == 0) begin
            r_wcnt  <= '0;
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_enc <= '0;
    end else begin
      r_vld[0] <= w_blk_fire;
      r_enc[0] <= blk_enc;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_enc[i] <= r_enc[i-1];
      end
    end
  end

  assign w_push_data.enc  = r_enc[LAT-1];
  assign w_push_data.data = cip_C;
  assign w_pop            = out_valid && out_ready;

  blink_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_vld[LAT-1]),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = rst && !w_fifo_empty;
  assign out_data  = w_head.data;
  assign out_enc   = w_head.enc;

  assign cip_enc = blk_enc;
  assign cip_P   = blk_data;
  assign cip_T   = blk_tweak;
  assign cip_K0  = r_k0;

endmodule

// File: tb/tb_blink_stream_ctrl.sv
// Self-checking bench for blink_stream_ctrl with a 2-cycle stub core and a
// queue-based reference model of accepted blocks and their delivery times.
module tb_blink_stream_ctrl;
  import blink_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] PAD = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam int M_LOAD = 0, M_RUN = 1, M_DRAIN = 2;

  logic          clk, rst;
  logic          key_valid, key_ready;
  logic [63:0]   key_word;
  logic          blk_valid, blk_ready, blk_enc;
  logic [63:0]   blk_tweak, blk_data;
  logic          out_valid, out_ready, out_enc;
  logic [63:0]   out_data;
  logic          cip_enc;
  logic [63:0]   cip_P, cip_T, cip_C;
  logic [447:0]  cip_K0;

  blink_stream_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_word(key_word),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_enc(blk_enc),
    .blk_tweak(blk_tweak), .blk_data(blk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_enc(out_enc),
    .cip_enc(cip_enc), .cip_P(cip_P), .cip_T(cip_T), .cip_K0(cip_K0), .cip_C(cip_C)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] fold(input logic [447:0] k);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 7; i++) f ^= k[64*i +: 64];
    return f;
  endfunction

  // Stub core: samples on one edge, result valid after the next.
  logic [63:0] core_s1, core_s2;
  always @(posedge clk) begin
    core_s1 <= cip_P ^ PAD ^ cip_T ^ fold(cip_K0);
    core_s2 <= core_s1;
  end
  assign cip_C = core_s2;

  typedef struct {
    logic        enc;
    logic [63:0] data;
    int          acc_edge;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_key [7];
  int          m_mode, m_wcnt, ecnt, last_acc, n_out;
  logic        last_fk, last_fb;
  int          checks = 0;
  int          failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_fold();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 7; i++) f ^= m_key[i];
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode   = M_LOAD;
    m_wcnt   = 0;
    last_acc = -100;
    for (int i = 0; i < 7; i++) m_key[i] = '0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model by the handshakes seen at the edge.
  task automatic tick();
    logic        fk, fb, fo, kv, be, vis;
    logic [63:0] kw, bd, bt;
    @(negedge clk);
    fk = key_valid && key_ready;
    fb = blk_valid && blk_ready;
    fo = out_valid && out_ready;
    kv = key_valid; kw = key_word;
    be = blk_enc;   bd = blk_data; bt = blk_tweak;
    vis = (q.size() > 0) && (q[0].acc_edge + LAT <= ecnt);
    if (!rst) begin
      chk1("rst_key_ready", key_ready, 1'b0);
      chk1("rst_blk_ready", blk_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
    end else begin
      chk1("key_ready", key_ready, m_mode == M_LOAD);
      chk1("blk_ready", blk_ready, (m_mode == M_RUN) && (q.size() < DEPTH));
      chk1("out_valid", out_valid, vis);
      if (vis) begin
        chk64("out_data", out_data, q[0].data);
        chk1("out_enc", out_enc, q[0].enc);
      end
    end
    @(posedge clk);
    ecnt++;
    last_fk = fk;
    last_fb = fb;
    if (rst) begin
      case (m_mode)
        M_LOAD: if (fk) begin
          m_key[m_wcnt] = kw;
          m_wcnt++;
          if (m_wcnt == 7) begin
            m_wcnt = 0;
            m_mode = M_RUN;
          end
        end
        M_RUN:   if (kv) m_mode = M_DRAIN;
        default: if (ecnt - last_acc > LAT) m_mode = M_LOAD;
      endcase
      if (fb) begin
        q.push_back('{enc: be, data: bd ^ PAD ^ bt ^ model_fold(), acc_edge: ecnt});
        last_acc = ecnt;
      end
      if (fo && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
    end
    #1;
  endtask

  task automatic send_key(input logic [63:0] w);
    key_valid = 1'b1;
    key_word  = w;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_fk) break;
    end
    if (!last_fk) chki("key_timeout", 0, 1);
    key_valid = 1'b0;
  endtask

  task automatic send_blk(input logic e, input logic [63:0] t, input logic [63:0] d);
    blk_valid = 1'b1;
    blk_enc   = e;
    blk_tweak = t;
    blk_data  = d;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_fb) break;
    end
    if (!last_fb) chki("blk_timeout", 0, 1);
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chki("drain_empty", q.size(), 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [63:0]  bp_d [10];
  logic [63:0]  bp_t [10];
  logic         bp_e [10];
  logic [63:0]  nk [7];
  logic [447:0] exp_k0;
  int           idx, n0, fires;

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_word = '0;
    blk_valid = 1'b0; blk_enc = 1'b0; blk_tweak = '0; blk_data = '0;
    out_ready = 1'b0; ecnt = 0; n_out = 0;
    last_fk = 1'b0; last_fb = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chkk("rst_k0", cip_K0, '0);
    chk64("rst_out_data", out_data, '0);
    chk1("rst_out_enc", out_enc, 1'b0);
    rst = 1'b1;

    // Key load 0x1..1 .. 0x7..7
    for (int i = 1; i <= 7; i++) begin
      send_key(64'h1111_1111_1111_1111 * i);
      exp_k0[64*(i-1) +: 64] = 64'h1111_1111_1111_1111 * i;
    end
    chkk("k0_loaded", cip_K0, exp_k0);
    chk1("key_ready_after_load", key_ready, 1'b0);

    // Combinational pass-through to the core
    blk_enc = 1'b1; blk_tweak = 64'hFEED_0000_BEEF_1234; blk_data = 64'h5555_AAAA_0F0F_F0F0;
    #1;
    chk1("cip_enc", cip_enc, 1'b1);
    chk64("cip_T", cip_T, 64'hFEED_0000_BEEF_1234);
    chk64("cip_P", cip_P, 64'h5555_AAAA_0F0F_F0F0);

    // Single block: visible three cycles after the acceptance cycle
    out_ready = 1'b1;
    send_blk(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF);
    tick();
    tick();
    chk1("single_valid", out_valid, 1'b1);
    chk64("single_data", out_data, 64'h0123_4567_89AB_CDEF ^ 64'hA5A5_A5A5_A5A5_A5A5);
    chk1("single_enc", out_enc, 1'b1);
    drain();

    // Backpressure: only DEPTH blocks accepted while the output is stalled
    for (int i = 0; i < 10; i++) begin
      bp_d[i] = rnd64(); bp_t[i] = rnd64(); bp_e[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    n0 = n_out;
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      blk_valid = 1'b1; blk_enc = bp_e[idx]; blk_tweak = bp_t[idx]; blk_data = bp_d[idx];
      tick();
      if (last_fb) idx++;
    end
    chki("bp_accepted", idx, DEPTH);
    chk1("bp_blk_ready", blk_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      blk_valid = 1'b1; blk_enc = bp_e[idx]; blk_tweak = bp_t[idx]; blk_data = bp_d[idx];
      tick();
      if (last_fb) idx++;
    end
    blk_valid = 1'b0;
    drain();
    chki("bp_delivered", n_out - n0, 10);

    // Streaming: one transfer per cycle with the output always ready
    n0 = n_out;
    fires = 0;
    blk_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      blk_enc = 1'($urandom_range(0, 1)); blk_tweak = rnd64(); blk_data = rnd64();
      tick();
      if (last_fb) fires++;
    end
    blk_valid = 1'b0;
    chki("stream_transfers", fires, 100);
    drain();
    chki("stream_delivered", n_out - n0, 100);

    // Rekey with two blocks in flight
    n0 = n_out;
    send_blk(1'b1, rnd64(), rnd64());
    send_blk(1'b0, rnd64(), rnd64());
    for (int i = 0; i < 7; i++) begin
      nk[i] = rnd64();
      exp_k0[64*i +: 64] = nk[i];
    end
    for (int i = 0; i < 7; i++) send_key(nk[i]);
    chkk("k0_rekeyed", cip_K0, exp_k0);
    chki("rekey_old_delivered", n_out - n0, 2);
    for (int i = 0; i < 3; i++) send_blk(1'($urandom_range(0, 1)), rnd64(), rnd64());
    drain();
    chki("rekey_new_delivered", n_out - n0, 5);

    // Reset mid-stream with results buffered and in flight
    out_ready = 1'b0;
    send_blk(1'b1, rnd64(), rnd64());
    send_blk(1'b0, rnd64(), rnd64());
    repeat (3) tick();
    send_blk(1'b1, rnd64(), rnd64());
    send_blk(1'b0, rnd64(), rnd64());
    rst = 1'b0;
    model_reset();
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_key_ready", key_ready, 1'b0);
    chkk("mid_rst_k0", cip_K0, '0);
    chk64("mid_rst_out_data", out_data, '0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (8) tick();
    chki("no_stale_results", n_out - n0, 0);
    for (int i = 0; i < 7; i++) send_key(rnd64());
    for (int i = 0; i < 4; i++) send_blk(1'($urandom_range(0, 1)), rnd64(), rnd64());
    drain();
    chki("post_rst_delivered", n_out - n0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
